// File: rtl/decod_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decod_pkg
// Brief    : Shared state encoding, mode constants and one-hot helper for
//            the decod_scan registered decoder.
// Revision : 1.0
// ============================================================================
package decod_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 6;

    // Widest supported decode; callers truncate to their own line count.
    function automatic logic [63:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        onehot = 64'd1 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decod_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : decod_scan_if
// Brief    : Control and select-line bundle between a controller and the
//            decod_scan decoder.
// Revision : 1.0
// ============================================================================
interface decod_scan_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 16
);
    import decod_pkg::*;

    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [DIV_W-1:0]      div;
    logic [(2**SEL_W)-1:0] y;
    logic [SEL_W-1:0]      idx;
    logic                  wrap;

    modport master (
        output en, mode, sel, div,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, sel, div,
        output y, idx, wrap
    );

endinterface
`default_nettype wire

// File: rtl/decod_scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : decod_prescaler
// Brief    : Scan-rate counter; ticks whenever the count has reached div.
// Revision : 1.0
// ============================================================================
module decod_prescaler
    import decod_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [DIV_W-1:0] i_div,
    output logic                  o_tick
);

    logic [DIV_W-1:0] r_cnt;

    // ">=" so that shrinking div below the live count fires at once.
    assign o_tick = (r_cnt >= i_div);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decod_scan.sv
`default_nettype none
// ============================================================================
// Module   : decod_scan
// Brief    : Registered one-hot decoder with enable, manual select and
//            prescaled auto-scan.
// Revision : 1.0
// ============================================================================
module decod_scan
    import decod_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    decod_scan_if.slave bus
);

    localparam int N = 2**SEL_W;

    localparam logic [1:0] c_ST_OFF    = OFF;
    localparam logic [1:0] c_ST_MANUAL = MANUAL;
    localparam logic [1:0] c_ST_SCAN   = SCAN;

    localparam logic [N-1:0] c_Y_IDLE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_idx;
    logic [N-1:0]     r_y;
    logic             r_wrap;

    logic [1:0]       w_nstate;
    logic [SEL_W-1:0] w_idx_next;
    logic [N-1:0]     w_onehot;
    logic             w_scan_entry;
    logic             w_scan_run;
    logic             w_tick;
    logic             w_adv;

    always_comb begin
        w_nstate = c_ST_OFF;
        if (bus.en) begin
            w_nstate = (bus.mode == MODE_SCAN) ? c_ST_SCAN : c_ST_MANUAL;
        end
    end

    // Entering scan restarts the step period but keeps the current index.
    assign w_scan_entry = (w_nstate == c_ST_SCAN) && (r_state != c_ST_SCAN);
    assign w_scan_run   = (w_nstate == c_ST_SCAN) && (r_state == c_ST_SCAN);
    assign w_adv        = w_scan_run && w_tick;

    decod_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_scan_entry || (w_nstate == c_ST_MANUAL)),
        .i_en   (w_scan_run),
        .i_div  (bus.div),
        .o_tick (w_tick)
    );

    always_comb begin
        w_idx_next = r_idx;
        case (w_nstate)
            c_ST_MANUAL: w_idx_next = bus.sel;
            c_ST_SCAN:   w_idx_next = w_adv ? r_idx + 1'b1 : r_idx;
            default:     w_idx_next = r_idx;
        endcase
    end

    // Decode the next index so y and idx change on the same edge.
    assign w_onehot = N'(onehot(MAX_SEL_W'(w_idx_next)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_OFF;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
            r_y     <= c_Y_IDLE;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_idx_next;
            r_wrap  <= w_adv && (r_idx == {SEL_W{1'b1}});
            r_y     <= (w_nstate == c_ST_OFF) ? c_Y_IDLE : (w_onehot ^ c_Y_IDLE);
        end
    end

    assign bus.y    = r_y;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire
